// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding,
// the default watchdog length and a constant-foldable clog2.
package fifo_arb_pkg;

   localparam logic [0:0] ARB_IDLE = 1'b0;
   localparam logic [0:0] ARB_LOCK = 1'b1;

   localparam int ARB_TIMEOUT_DEF = 16;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted request after rr_ptr,
// wrapping modulo NUM_REQ.
module rr_priority_picker #(
   parameter int NUM_REQ = 2,
   parameter int IDW     = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     rr_ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDW-1:0]     idx,
   output logic               any
);

   // Scan farthest offset first so the nearest valid requester overwrites it.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         int j;
         j = int'(rr_ptr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (req[j]) begin
            gnt = NUM_REQ'(1) << j;
            idx = IDW'(j);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port between producers,
// with frame locking and an owner-stall watchdog.
//
// state    | meaning
// ARB_IDLE | arbitrate every cycle; single-beat frames complete here
// ARB_LOCK | grant held by owner until its LAST beat or watchdog release
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = ARB_TIMEOUT_DEF,
   localparam int IDW       = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_REQ-1:0]            REQ_VALID,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
   input  logic [NUM_REQ-1:0]            REQ_LAST,
   output logic [NUM_REQ-1:0]            REQ_READY,
   input  logic                          W_full,
   output logic                          W_INC,
   output logic [DATA_WIDTH-1:0]         WR_DATA,
   output logic [IDW-1:0]                GRANT_ID,
   output logic                          BUSY,
   output logic                          TIMEOUT_ERR
);

   localparam int CW = clog2(TIMEOUT + 1);

   logic [0:0]         state;
   logic [IDW-1:0]     rr_ptr;
   logic [IDW-1:0]     owner;
   logic [CW-1:0]      idle_cnt;
   logic [IDW-1:0]     last_gid;
   logic               timeout_err_q;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [IDW-1:0]     pick_idx;
   logic               pick_any;
   logic               lock;
   logic [IDW-1:0]     win_idx;
   logic               win_valid;
   logic               win_last;
   logic               accept;
   logic [IDW-1:0]     gid_int;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_picker (
      .req    (REQ_VALID),
      .rr_ptr (rr_ptr),
      .gnt    (pick_gnt),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   assign lock      = (state == ARB_LOCK);
   assign win_idx   = lock ? owner : pick_idx;
   assign win_valid = lock ? REQ_VALID[owner] : pick_any;
   assign win_last  = REQ_LAST[win_idx];
   // Outputs are forced quiet while the async reset is held, not just after it.
   assign accept    = win_valid & ~W_full & RST;
   assign gid_int   = lock ? owner : (pick_any ? pick_idx : last_gid);

   assign W_INC       = accept;
   assign WR_DATA     = REQ_DATA[win_idx*DATA_WIDTH +: DATA_WIDTH];
   assign REQ_READY   = (RST && !W_full) ? (lock ? (NUM_REQ'(1) << owner) : pick_gnt) : '0;
   assign GRANT_ID    = RST ? gid_int : '0;
   assign BUSY        = lock;
   assign TIMEOUT_ERR = timeout_err_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state         <= ARB_IDLE;
         rr_ptr        <= IDW'(NUM_REQ - 1);
         owner         <= '0;
         idle_cnt      <= '0;
         last_gid      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         timeout_err_q <= 1'b0;
         last_gid      <= gid_int;
         if (!lock) begin
            if (accept) begin
               if (win_last) begin
                  rr_ptr <= pick_idx;
               end else begin
                  state    <= ARB_LOCK;
                  owner    <= pick_idx;
                  idle_cnt <= '0;
               end
            end
         end else if (accept) begin
            idle_cnt <= '0;
            if (win_last) begin
               state  <= ARB_IDLE;
               rr_ptr <= owner;
            end
         end else if (REQ_VALID[owner]) begin
            // Stalled only by W_full: the owner is still alive.
            idle_cnt <= '0;
         end else if (idle_cnt >= CW'(TIMEOUT - 2)) begin
            state         <= ARB_IDLE;
            rr_ptr        <= owner;
            idle_cnt      <= '0;
            timeout_err_q <= 1'b1;
         end else if (idle_cnt != {CW{1'b1}}) begin
            idle_cnt <= idle_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a 2-requester instance for frames,
// full stalls, watchdog and reset, plus a 3-requester instance for the wrap.
module tb_fifo_wr_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  rv, rl, rdy;
   logic [15:0] rd;
   logic        full;
   logic        winc;
   logic [7:0]  wdata;
   logic [0:0]  gid;
   logic        busy, terr;

   logic [2:0]  v3, l3, rdy3;
   logic [23:0] d3;
   logic        full3;
   logic        winc3;
   logic [7:0]  wdata3;
   logic [1:0]  gid3;
   logic        busy3, terr3;

   fifo_wr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .TIMEOUT(16)) dut2 (
      .CLK(clk), .RST(rst_n), .REQ_VALID(rv), .REQ_DATA(rd), .REQ_LAST(rl),
      .REQ_READY(rdy), .W_full(full), .W_INC(winc), .WR_DATA(wdata),
      .GRANT_ID(gid), .BUSY(busy), .TIMEOUT_ERR(terr)
   );

   fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .TIMEOUT(16)) dut3 (
      .CLK(clk), .RST(rst_n), .REQ_VALID(v3), .REQ_DATA(d3), .REQ_LAST(l3),
      .REQ_READY(rdy3), .W_full(full3), .W_INC(winc3), .WR_DATA(wdata3),
      .GRANT_ID(gid3), .BUSY(busy3), .TIMEOUT_ERR(terr3)
   );

   int errors = 0;
   int checks = 0;

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [8:0] exp_q[$];
   int         exp3[$];

   logic       s_busy, s_err, s_inc;
   logic [1:0] s_rdy;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_word(input int r, input logic [7:0] d, input logic last);
      if (r == 0) q0.push_back({last, d});
      else        q1.push_back({last, d});
   endtask

   task automatic expect_wr(input logic id, input logic [7:0] d);
      exp_q.push_back({id, d});
   endtask

   task automatic cycle();
      logic [1:0] acc;
      logic [8:0] e;
      rv[0]    = (q0.size() != 0);
      rv[1]    = (q1.size() != 0);
      rd[7:0]  = rv[0] ? q0[0][7:0] : 8'h00;
      rd[15:8] = rv[1] ? q1[0][7:0] : 8'h00;
      rl[0]    = rv[0] ? q0[0][8] : 1'b0;
      rl[1]    = rv[1] ? q1[0][8] : 1'b0;
      @(negedge clk);
      s_busy = busy;
      s_err  = terr;
      s_inc  = winc;
      s_rdy  = rdy;
      if (winc) begin
         chk("sb_avail", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_data", wdata, e[7:0]);
            chk("grant_id", gid, e[8]);
         end
      end
      acc = rv & rdy;
      @(posedge clk);
      #1;
      if (acc[0]) q0.pop_front();
      if (acc[1]) q1.pop_front();
   endtask

   task automatic drain(input int max_cyc);
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0) && n < max_cyc) begin
         cycle();
         n++;
      end
      chk("drain_bound", q0.size() + q1.size() + exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int nw, nb;
      rv = '0; rl = '0; rd = '0; full = 1'b0;
      v3 = '0; l3 = '0; d3 = '0; full3 = 1'b0;

      // reset with requests present
      repeat (2) @(posedge clk);
      #1 rv = 2'b11; rl = 2'b11;
      @(negedge clk);
      chk("rst_ready", rdy, 0);
      chk("rst_winc", winc, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gid", gid, 0);
      chk("rst_terr", terr, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: alternating single-beat writes, req0 first
      for (int k = 0; k < 4; k++) begin
         push_word(0, 8'h10 + 8'(k), 1'b1);
         push_word(1, 8'h20 + 8'(k), 1'b1);
         expect_wr(1'b0, 8'h10 + 8'(k));
         expect_wr(1'b1, 8'h20 + 8'(k));
      end
      nw = 0;
      repeat (8) begin
         cycle();
         nw += int'(s_inc);
      end
      chk("t1_writes", nw, 8);

      // 2: 3-beat frame from req1 stays contiguous
      push_word(0, 8'h2F, 1'b1);
      expect_wr(1'b0, 8'h2F);
      cycle();
      push_word(1, 8'hA1, 1'b0);
      push_word(1, 8'hA2, 1'b0);
      push_word(1, 8'hA3, 1'b1);
      push_word(0, 8'h30, 1'b1);
      expect_wr(1'b1, 8'hA1);
      expect_wr(1'b1, 8'hA2);
      expect_wr(1'b1, 8'hA3);
      expect_wr(1'b0, 8'h30);
      nb = 0;
      repeat (4) begin
         cycle();
         nb += int'(s_busy);
      end
      chk("t2_busy_cycles", nb, 2);

      // 3: FIFO full mid-frame, owner holds its word
      push_word(1, 8'hB1, 1'b0);
      push_word(1, 8'hB2, 1'b0);
      push_word(1, 8'hB3, 1'b1);
      push_word(0, 8'h40, 1'b1);
      expect_wr(1'b1, 8'hB1);
      expect_wr(1'b1, 8'hB2);
      expect_wr(1'b1, 8'hB3);
      expect_wr(1'b0, 8'h40);
      cycle();
      full = 1'b1;
      repeat (5) begin
         cycle();
         chk("t3_winc", s_inc, 0);
         chk("t3_ready", s_rdy, 0);
         chk("t3_terr", s_err, 0);
         chk("t3_busy", s_busy, 1);
      end
      full = 1'b0;
      drain(10);

      // 4: owner stalls after one beat, watchdog releases on stall cycle 16
      push_word(1, 8'hC1, 1'b0);
      push_word(0, 8'h50, 1'b1);
      expect_wr(1'b1, 8'hC1);
      expect_wr(1'b0, 8'h50);
      cycle();
      for (int s = 1; s <= 17; s++) begin
         cycle();
         chk($sformatf("t4_terr_s%0d", s), s_err, (s == 16) ? 1 : 0);
         chk($sformatf("t4_busy_s%0d", s), s_busy, (s <= 15) ? 1 : 0);
      end
      chk("t4_sb_empty", exp_q.size(), 0);

      // 5: reset while locked
      push_word(1, 8'hD1, 1'b0);
      push_word(1, 8'hD2, 1'b0);
      push_word(1, 8'hD3, 1'b1);
      expect_wr(1'b1, 8'hD1);
      cycle();
      chk("t5_busy_pre", busy, 1);
      rst_n = 1'b0;
      repeat (2) begin
         cycle();
         chk("t5_rst_busy", s_busy, 0);
         chk("t5_rst_winc", s_inc, 0);
         chk("t5_rst_ready", s_rdy, 0);
      end
      rst_n = 1'b1;
      push_word(0, 8'h60, 1'b1);
      expect_wr(1'b0, 8'h60);
      expect_wr(1'b1, 8'hD2);
      expect_wr(1'b1, 8'hD3);
      drain(10);

      // 6: three requesters, rr_ptr wraps 2 -> 0
      for (int k = 0; k < 4; k++) exp3.push_back(k % 3);
      v3 = 3'b111; l3 = 3'b111; d3 = {8'h72, 8'h71, 8'h70};
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t6_winc", winc3, 1);
         if (winc3 && exp3.size() != 0) begin
            int e;
            e = exp3.pop_front();
            chk("t6_gid", gid3, e);
            chk("t6_data", wdata3, 8'h70 + e);
         end
         @(posedge clk);
         #1;
      end
      v3 = '0;

      chk("sb_drain", exp_q.size() + exp3.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
